// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file port arbiter.
// Holds FSM states, debug op codes and register-file geometry.
package regfile_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ACCESS,
    CLEAR,
    RESP
  } arb_state_t;

  typedef logic [1:0] dbg_op_t;

  localparam dbg_op_t OP_READ  = 2'b00;
  localparam dbg_op_t OP_WRITE = 2'b01;
  localparam dbg_op_t OP_CLEAR = 2'b10;

endpackage

// File: rtl/regfile_port_arbiter_sweep_ctr.sv
// Loadable up-counter with terminal flag.
// Shared by the drain wait and the clear sweep.
module rf_sweep_ctr
  import regfile_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  en,
  input  logic [REG_ADDR_W-1:0] load_val,
  input  logic [REG_ADDR_W-1:0] last,
  output logic [REG_ADDR_W-1:0] cnt,
  output logic                  done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + REG_ADDR_W'(1);
    end
  end

  assign done = (cnt == last);

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file write port and rs1 read path
// between the core and the UART debug unit.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_wr,
  input  logic [REG_ADDR_W-1:0] core_addr_rd,
  input  logic [DATA_W-1:0]     core_rd,
  input  logic [REG_ADDR_W-1:0] core_addr_rs1,
  input  logic [REG_ADDR_W-1:0] core_addr_rs2,
  output logic [DATA_W-1:0]     core_rs1,
  output logic [DATA_W-1:0]     core_rs2,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic [1:0]            dbg_op,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  rf_wr,
  output logic [REG_ADDR_W-1:0] rf_addr_rd,
  output logic [DATA_W-1:0]     rf_rd,
  output logic [REG_ADDR_W-1:0] rf_addr_rs1,
  output logic [REG_ADDR_W-1:0] rf_addr_rs2,
  input  logic [DATA_W-1:0]     rf_rs1,
  input  logic [DATA_W-1:0]     rf_rs2
);

  localparam logic [REG_ADDR_W-1:0] ONE =
    REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] DRAIN_LAST =
    REG_ADDR_W'(DRAIN_CYCLES);
  localparam logic [REG_ADDR_W-1:0] SWEEP_LAST =
    REG_ADDR_W'(NUM_REGS - 1);

  arb_state_t state, next_state;

  dbg_op_t               op_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  armed;

  logic                  ctr_load;
  logic                  ctr_en;
  logic [REG_ADDR_W-1:0] ctr_last;
  logic [REG_ADDR_W-1:0] ctr_cnt;
  logic                  ctr_done;

  rf_sweep_ctr u_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .en       (ctr_en),
    .load_val (ONE),
    .last     (ctr_last),
    .cnt      (ctr_cnt),
    .done     (ctr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ctr_load   = 1'b0;
    ctr_en     = 1'b0;
    ctr_last   = DRAIN_LAST;
    unique case (state)
      IDLE: begin
        if (dbg_req && armed) begin
          next_state = DRAIN;
          ctr_load   = 1'b1;
        end
      end
      DRAIN: begin
        if (ctr_done) begin
          ctr_load   = 1'b1;
          next_state = (op_q == OP_CLEAR) ? CLEAR : ACCESS;
        end else begin
          ctr_en = 1'b1;
        end
      end
      ACCESS: next_state = RESP;
      CLEAR: begin
        ctr_last = SWEEP_LAST;
        if (ctr_done) begin
          next_state = RESP;
        end else begin
          ctr_en = 1'b1;
        end
      end
      RESP: begin
        if (!dbg_req) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Core owns the ports except during the debug access itself.
  always_comb begin
    rf_wr       = core_wr;
    rf_addr_rd  = core_addr_rd;
    rf_rd       = core_rd;
    rf_addr_rs1 = core_addr_rs1;
    unique case (1'b1)
      (state == ACCESS): begin
        rf_wr       = (op_q == OP_WRITE) && (addr_q != '0);
        rf_addr_rd  = addr_q;
        rf_rd       = wdata_q;
        rf_addr_rs1 = addr_q;
      end
      (state == CLEAR): begin
        rf_wr      = 1'b1;
        rf_addr_rd = ctr_cnt;
        rf_rd      = '0;
      end
      default: ;
    endcase
  end

  assign rf_addr_rs2 = core_addr_rs2;
  assign core_rs1    = rf_rs1;
  assign core_rs2    = rf_rs2;

  // armed needs one idle cycle with req low, so a held req never retriggers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_stall <= 1'b0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= '0;
      armed      <= 1'b0;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      core_stall <= (next_state != IDLE);
      dbg_ack    <= (state == RESP) && (next_state == RESP);
      if (state != IDLE) begin
        armed <= 1'b0;
      end else if (!dbg_req) begin
        armed <= 1'b1;
      end
      if (state == IDLE && next_state == DRAIN) begin
        op_q    <= dbg_op;
        addr_q  <= dbg_addr;
        wdata_q <= dbg_wdata;
      end
      if (state == ACCESS && op_q != OP_WRITE) begin
        dbg_rdata <= rf_rs1;
      end
    end
  end

endmodule
